wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: none; FIFO depth fixed at 2, starvation limit fixed at 3 cycles.
REQ-002 clk  in  1  clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 iss_en  in  1  long-latency op issued this cycle; marks iss_rd pending.
REQ-005 iss_rd  in  5  destination of issued long-latency op.
REQ-006 iss_stall  out  1  combinational: iss_en & pending[iss_rd] & iss_rd!=0.
REQ-007 pw_en / pw_addr / pw_data  in  1/5/32  single-cycle pipeline writeback.
REQ-008 pw_hold  out  1  registered; requests pipeline suppress pw_en next cycle.
REQ-009 lw_valid / lw_addr / lw_data  in  1/5/32  long-latency result, valid/ready.
REQ-010 lw_ready  out  1  combinational: FIFO not full and not in reset.
REQ-011 q_rs1 / q_rs2  in  5  hazard query addresses.
REQ-012 q_rs1_busy / q_rs2_busy  out  1  combinational: pending[q_rsX], 0 for x0.
REQ-013 wr_en / wr_addr / wr_data  out  1/5/32  registered register-file write port.

Function
REQ-014 lw transfer occurs on edge where lw_valid & lw_ready; entry {addr,data} pushed to FIFO tail.
REQ-015 lw_data/lw_addr shall be held stable by producer while lw_valid & !lw_ready.
REQ-016 Per-cycle selection: pw_en -> pipe source; else FIFO non-empty -> pop head; else idle.
REQ-017 Selected source registered onto wr_* at next edge: latency exactly 1 cycle.
REQ-018 wr_en=1 only if selected addr != 0; x0 pops consume the slot with wr_en=0.
REQ-019 Idle cycle: wr_en=0; wr_addr/wr_data hold previous values.
REQ-020 Push and pop in the same cycle legal when FIFO non-empty; count unchanged; full FIFO with simultaneous pop: lw_ready stays 0 that cycle (ready from pre-edge count).
REQ-021 pending[31:1] set at edge when iss_en & !iss_stall & iss_rd!=0.
REQ-022 pending[a] cleared at the edge that asserts wr_en with wr_addr=a from a FIFO pop (not from pipe source).
REQ-023 Set and clear of same bit on same edge: set wins.
REQ-024 Busy therefore deasserts in the cycle wr_en presents the value, allowing regfile same-cycle bypass.
REQ-025 Starvation counter (2 bits): increments each cycle FIFO non-empty and pw_en=1; clears on any pop or FIFO empty.
REQ-026 pw_hold registered high on edge where counter reaches 3; cleared on the edge following a pop.
REQ-027 If pw_en asserted while pw_hold=1, pipe still wins; counter saturates at 3, pw_hold stays 1.
REQ-028 FIFO pointers 1-bit each, wrap modulo 2; count 0..2.

Reset
REQ-029 While rst=1: wr_en=0, wr_addr=0, wr_data=0, pw_hold=0, lw_ready=0, pending=0, FIFO empty, counter=0.
REQ-030 Reset mid-operation discards FIFO contents and pending bits; no write issued for discarded entries.
REQ-031 First edge after rst deassert: lw_ready=1, all busy outputs 0.

Verification
REQ-032 Pipe write: pw_en=1,addr=5,data=0xDEADBEEF -> next cycle wr_en=1,wr_addr=5,wr_data=0xDEADBEEF.
REQ-033 Scoreboard: iss_en,rd=7; later lw addr=7,data=0x1234 with pw_en=0 -> q_rs1=7 busy until wr_en cycle; wr_en cycle wr_addr=7,busy=0.
REQ-034 Backpressure: pw_en=1 continuously, three lw pushes (addr 1,2,3) -> lw_ready=0 after 2 accepted; pw_hold=1 after 3 blocked cycles; releasing pw_en drains 1 then 2 in order.
REQ-035 Collision: pending[9] drained on same edge as iss_en,rd=9 -> pending[9]=1 afterwards; iss_en,rd=9 again -> iss_stall=1.
REQ-036 x0: pw_en addr=0 and lw addr=0 -> no wr_en pulse; FIFO pops; q_rs1=0 busy=0.
REQ-037 Async reset with FIFO full and pending[4]=1 -> outputs zero immediately, no later write to r4, lw_ready=1 after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: issue/scoreboard, pipeline writeback, long-latency
// writeback (valid/ready), hazard query and register-file write port.
interface wb_arbiter_if;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        pw_en;
  logic [4:0]  pw_addr;
  logic [31:0] pw_data;
  logic        pw_hold;
  logic        lw_valid;
  logic [4:0]  lw_addr;
  logic [31:0] lw_data;
  logic        lw_ready;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_rs1_busy;
  logic        q_rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // lw handshake: a transfer happens on every rising edge where lw_valid and
  // lw_ready are both high; the producer holds lw_addr/lw_data stable while
  // lw_valid is high and lw_ready is low, and ready never waits on valid.
  modport master (
    output iss_en, iss_rd, pw_en, pw_addr, pw_data,
           lw_valid, lw_addr, lw_data, q_rs1, q_rs2,
    input  iss_stall, pw_hold, lw_ready, q_rs1_busy, q_rs2_busy,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    input  iss_en, iss_rd, pw_en, pw_addr, pw_data,
           lw_valid, lw_addr, lw_data, q_rs1, q_rs2,
    output iss_stall, pw_hold, lw_ready, q_rs1_busy, q_rs2_busy,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: pipeline writes win, long-latency results queue
// in a 2-entry FIFO, with a pending-register scoreboard and starvation hold.
module wb_arbiter (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  logic [36:0] fifo_mem [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic [1:0]  starve;
  logic [1:0]  starve_next;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        set_pend;

  assign head_addr = fifo_mem[rptr][36:32];
  assign head_data = fifo_mem[rptr][31:0];

  assign bus.lw_ready   = !rst && (count != 2'd2);
  assign bus.iss_stall  = bus.iss_en && pending[bus.iss_rd] && (bus.iss_rd != 5'd0);
  assign bus.q_rs1_busy = pending[bus.q_rs1] && (bus.q_rs1 != 5'd0);
  assign bus.q_rs2_busy = pending[bus.q_rs2] && (bus.q_rs2 != 5'd0);

  assign push     = bus.lw_valid && bus.lw_ready;
  assign pop      = !bus.pw_en && (count != 2'd0);
  assign set_pend = bus.iss_en && !bus.iss_stall && (bus.iss_rd != 5'd0);
  assign sel_addr = bus.pw_en ? bus.pw_addr : head_addr;
  assign sel_data = bus.pw_en ? bus.pw_data : head_data;

  always_comb begin
    starve_next = starve;
    if (pop || count == 2'd0)
      starve_next = 2'd0;
    else if (bus.pw_en && starve != 2'd3)
      starve_next = starve + 2'd1;
  end

  // Clear from a FIFO drain first so a same-edge issue to that register wins.
  always_comb begin
    pending_next = pending;
    if (pop && head_addr != 5'd0)
      pending_next[head_addr] = 1'b0;
    if (set_pend)
      pending_next[bus.iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= 2'd0;
      starve      <= 2'd0;
      pending     <= '0;
      bus.pw_hold <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= 5'd0;
      bus.wr_data <= 32'd0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= {bus.lw_addr, bus.lw_data};
        wptr           <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      count       <= count + {1'b0, push} - {1'b0, pop};
      starve      <= starve_next;
      bus.pw_hold <= (starve_next == 2'd3);
      pending     <= pending_next;
      // x0 selections still consume their slot but never raise wr_en.
      if (bus.pw_en || pop) begin
        bus.wr_en   <= (sel_addr != 5'd0);
        bus.wr_addr <= sel_addr;
        bus.wr_data <= sel_data;
      end else begin
        bus.wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: pipe writes, scoreboard, backpressure,
// set/clear collision, x0 handling and asynchronous reset mid-operation.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [36:0] exp_q[$];
  logic [36:0] exp_item;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_en   = 1'b0;
    bus.iss_rd   = 5'd0;
    bus.pw_en    = 1'b0;
    bus.pw_addr  = 5'd0;
    bus.pw_data  = 32'd0;
    bus.lw_valid = 1'b0;
    bus.lw_addr  = 5'd0;
    bus.lw_data  = 32'd0;
    bus.q_rs1    = 5'd0;
    bus.q_rs2    = 5'd0;
  endtask

  task automatic lw_drive(input logic [4:0] a, input logic [31:0] d);
    bus.lw_valid = 1'b1;
    bus.lw_addr  = a;
    bus.lw_data  = d;
  endtask

  task automatic pw_drive(input logic [4:0] a, input logic [31:0] d);
    bus.pw_en   = 1'b1;
    bus.pw_addr = a;
    bus.pw_data = d;
  endtask

  task automatic check_drain(input string tag);
    exp_item = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h1F_FFFF_FFFF;
    check({tag, "_en"}, {36'd0, bus.wr_en}, 37'd1);
    check(tag, {bus.wr_addr, bus.wr_data}, exp_item);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_wr_en",    {36'd0, bus.wr_en},    37'd0);
    check("rst_wr_addr",  {32'd0, bus.wr_addr},  37'd0);
    check("rst_wr_data",  {5'd0,  bus.wr_data},  37'd0);
    check("rst_pw_hold",  {36'd0, bus.pw_hold},  37'd0);
    check("rst_lw_ready", {36'd0, bus.lw_ready}, 37'd0);
    rst = 1'b0;
    step();
    check("post_rst_ready", {36'd0, bus.lw_ready}, 37'd1);
    check("post_rst_busy1", {36'd0, bus.q_rs1_busy}, 37'd0);

    // pipe write: one-cycle latency, then idle holds addr/data
    pw_drive(5'd5, 32'hDEADBEEF);
    step();
    bus.pw_en = 1'b0;
    check("pipe_wr_en",   {36'd0, bus.wr_en},   37'd1);
    check("pipe_wr_addr", {32'd0, bus.wr_addr}, 37'd5);
    check("pipe_wr_data", {5'd0,  bus.wr_data}, 37'hDEADBEEF);
    step();
    check("idle_wr_en",   {36'd0, bus.wr_en},   37'd0);
    check("idle_wr_addr", {32'd0, bus.wr_addr}, 37'd5);
    check("idle_wr_data", {5'd0,  bus.wr_data}, 37'hDEADBEEF);

    // scoreboard: issue r7, busy until the long-latency write presents
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd7;
    bus.q_rs1  = 5'd7;
    bus.q_rs2  = 5'd7;
    settle();
    check("sb_no_stall", {36'd0, bus.iss_stall}, 37'd0);
    step();
    bus.iss_en = 1'b0;
    settle();
    check("sb_busy1", {36'd0, bus.q_rs1_busy}, 37'd1);
    check("sb_busy2", {36'd0, bus.q_rs2_busy}, 37'd1);
    lw_drive(5'd7, 32'h1234);
    settle();
    check("sb_lw_ready", {36'd0, bus.lw_ready}, 37'd1);
    step();
    bus.lw_valid = 1'b0;
    settle();
    check("sb_busy_queued", {36'd0, bus.q_rs1_busy}, 37'd1);
    step();
    check("sb_wr_en",   {36'd0, bus.wr_en},   37'd1);
    check("sb_wr_addr", {32'd0, bus.wr_addr}, 37'd7);
    check("sb_wr_data", {5'd0,  bus.wr_data}, 37'h1234);
    check("sb_busy_clr", {36'd0, bus.q_rs1_busy}, 37'd0);

    // collision: drain of r9 on the same edge as a new issue to r9
    lw_drive(5'd9, 32'h99);
    step();
    bus.lw_valid = 1'b0;
    bus.iss_en   = 1'b1;
    bus.iss_rd   = 5'd9;
    bus.q_rs1    = 5'd9;
    settle();
    check("col_no_stall", {36'd0, bus.iss_stall}, 37'd0);
    step();
    check("col_wr_addr", {32'd0, bus.wr_addr}, 37'd9);
    settle();
    check("col_busy", {36'd0, bus.q_rs1_busy}, 37'd1);
    check("col_stall", {36'd0, bus.iss_stall}, 37'd1);
    step();
    bus.iss_en = 1'b0;

    // x0: neither source raises wr_en; the FIFO slot is still consumed
    pw_drive(5'd0, 32'hAAAA);
    step();
    bus.pw_en = 1'b0;
    check("x0_pipe_wr_en", {36'd0, bus.wr_en}, 37'd0);
    lw_drive(5'd0, 32'h5555);
    step();
    bus.lw_valid = 1'b0;
    step();
    check("x0_lw_wr_en", {36'd0, bus.wr_en}, 37'd0);
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd0;
    bus.q_rs1  = 5'd0;
    settle();
    check("x0_stall", {36'd0, bus.iss_stall}, 37'd0);
    step();
    bus.iss_en = 1'b0;
    settle();
    check("x0_busy", {36'd0, bus.q_rs1_busy}, 37'd0);

    // backpressure: pipe hogs the port, FIFO fills, hold rises, then drains in order
    pw_drive(5'd20, 32'h2020);
    lw_drive(5'd1, 32'h11);
    settle();
    check("bp_ready0", {36'd0, bus.lw_ready}, 37'd1);
    step();
    exp_q.push_back({5'd1, 32'h11});
    lw_drive(5'd2, 32'h22);
    settle();
    check("bp_ready1", {36'd0, bus.lw_ready}, 37'd1);
    step();
    exp_q.push_back({5'd2, 32'h22});
    lw_drive(5'd3, 32'h33);
    settle();
    check("bp_full", {36'd0, bus.lw_ready}, 37'd0);
    check("bp_hold_c1", {36'd0, bus.pw_hold}, 37'd0);
    step();
    check("bp_hold_c2", {36'd0, bus.pw_hold}, 37'd0);
    step();
    check("bp_hold_set", {36'd0, bus.pw_hold}, 37'd1);
    step();
    check("bp_hold_sat", {36'd0, bus.pw_hold}, 37'd1);
    check("bp_pipe_wins", {32'd0, bus.wr_addr}, 37'd20);
    bus.pw_en = 1'b0;
    settle();
    check("bp_ready_pop_full", {36'd0, bus.lw_ready}, 37'd0);
    step();
    check_drain("bp_drain1");
    check("bp_hold_clr", {36'd0, bus.pw_hold}, 37'd0);
    settle();
    check("bp_ready_reopen", {36'd0, bus.lw_ready}, 37'd1);
    step();
    exp_q.push_back({5'd3, 32'h33});
    bus.lw_valid = 1'b0;
    check_drain("bp_drain2");
    step();
    check_drain("bp_drain3");
    step();
    check("bp_empty_idle", {36'd0, bus.wr_en}, 37'd0);
    check("bp_q_empty", {5'd0, 32'(exp_q.size())}, 37'd0);

    // async reset with FIFO full and r4 pending
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd4;
    bus.q_rs1  = 5'd4;
    step();
    bus.iss_en = 1'b0;
    pw_drive(5'd12, 32'hCAFE);
    lw_drive(5'd4, 32'h44);
    step();
    lw_drive(5'd6, 32'h66);
    step();
    bus.lw_valid = 1'b0;
    settle();
    check("ar_full", {36'd0, bus.lw_ready}, 37'd0);
    check("ar_busy_pre", {36'd0, bus.q_rs1_busy}, 37'd1);
    check("ar_wr_en_pre", {36'd0, bus.wr_en}, 37'd1);
    bus.pw_en = 1'b0;
    rst = 1'b1;
    settle();
    check("ar_wr_en",   {36'd0, bus.wr_en},      37'd0);
    check("ar_wr_addr", {32'd0, bus.wr_addr},    37'd0);
    check("ar_wr_data", {5'd0,  bus.wr_data},    37'd0);
    check("ar_ready",   {36'd0, bus.lw_ready},   37'd0);
    check("ar_busy",    {36'd0, bus.q_rs1_busy}, 37'd0);
    check("ar_hold",    {36'd0, bus.pw_hold},    37'd0);
    step();
    step();
    rst = 1'b0;
    settle();
    check("ar_release_ready", {36'd0, bus.lw_ready}, 37'd1);
    check("ar_release_busy",  {36'd0, bus.q_rs1_busy}, 37'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ar_no_write", {36'd0, bus.wr_en}, 37'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
